// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtract controller: drives an external 1-bit full-subtractor
// cell LSB first, chaining its borrow through a register, and collects DIFF = A - B - BIN.
module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         fs_a,
    output logic         fs_b,
    output logic         fs_bin,
    input  logic         fs_diff,
    input  logic         fs_bout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    diff_sh;
    logic            borrow;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    diff_next;

    // The cell is combinational, so the current bit resolves within this cycle.
    assign fs_a      = a_sh[0];
    assign fs_b      = b_sh[0];
    assign fs_bin    = borrow;
    assign diff_next = {fs_diff, diff_sh[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below sees
            // the pre-edge register values regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_next;
                    borrow  <= fs_bout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        diff  <= diff_next;
                        bout  <= fs_bout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at W=4 with a behavioural full-subtractor
// cell wired to the fs_* ports.
module tb_serial_sub_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         fs_a;
    logic         fs_b;
    logic         fs_bin;
    logic         fs_diff;
    logic         fs_bout;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .fs_a    (fs_a),
        .fs_b    (fs_b),
        .fs_bin  (fs_bin),
        .fs_diff (fs_diff),
        .fs_bout (fs_bout),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout)
    );

    assign fs_diff = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called just after the edge that accepted start; returns at the negedge
    // where done should be high.
    task automatic wait_done(input string tag, input bit chk_busy);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (chk_busy) check({tag, "_busy_cycles"}, n, W);
        check({tag, "_done"}, done, 1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_bin, input logic [W:0] exp_res, input bit chk_busy);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        bin   = op_bin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, chk_busy);
        check({tag, "_result"}, {bout, diff}, exp_res);
    endtask

    initial begin
        logic [W:0] model;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", {bout, diff}, 0);
        check("rst_fs", {fs_a, fs_b, fs_bin}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 9 - 3 - 0 = 6, then done must drop after one cycle with result held.
        do_op("t1", 4'd9, 4'd3, 1'b0, {1'b0, 4'd6}, 1'b1);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_hold", {bout, diff}, {1'b0, 4'd6});
        check("t1_fs_known", $isunknown({fs_a, fs_b, fs_bin}), 0);

        // start held through RUN with new operands: first result unaffected.
        @(negedge clk);
        a     = 4'd9;
        b     = 4'd3;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 4'd5;
        b = 4'd1;
        wait_done("t4a", 1'b1);
        check("t4a_result", {bout, diff}, {1'b0, 4'd6});
        @(negedge clk);
        check("t4_idle_busy", busy, 0);
        check("t4_idle_hold", {bout, diff}, {1'b0, 4'd6});
        @(posedge clk);
        #1 start = 1'b0;
        check("t4_restart_busy", busy, 1);
        wait_done("t4b", 1'b1);
        check("t4b_result", {bout, diff}, {1'b0, 4'd4});

        do_op("t2", 4'd3, 4'd9, 1'b0, {1'b1, 4'd10}, 1'b1);
        do_op("t3a", 4'd0, 4'd0, 1'b1, {1'b1, 4'd15}, 1'b1);
        do_op("t3b", 4'd15, 4'd15, 1'b1, {1'b1, 4'd15}, 1'b1);

        // Reset asserted during the second RUN cycle clears everything at once.
        @(negedge clk);
        a     = 4'd9;
        b     = 4'd3;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_result", {bout, diff}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("t5", 4'd7, 4'd2, 1'b0, {1'b0, 4'd5}, 1'b1);

        // Exhaustive back-to-back sweep against an unsigned A-B-BIN model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    model = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
                    do_op($sformatf("ex_%0d_%0d_%0d", ia, ib, ic),
                          4'(ia), 4'(ib), 1'(ic), model, 1'b0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
